// File: rtl/vending_fsm.sv
// Vending machine transaction controller: product selection, coin
// collection with overflow-safe credit, dispense strobe, change/refund
// computation and a timed result hold for the display controller.
module vending_fsm #(
    parameter int unsigned PRICE0      = 15,
    parameter int unsigned PRICE1      = 20,
    parameter int unsigned PRICE2      = 25,
    parameter int unsigned PRICE3      = 30,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       select_valid,
    input  logic [1:0] product_sel,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       cancel,
    output logic [5:0] cost_of_product,
    output logic [5:0] change,
    output logic [5:0] credit,
    output logic       dispense,
    output logic [1:0] product_id,
    output logic       coin_reject,
    output logic       busy
);

    localparam int unsigned  CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    cost_q, cost_d;
    logic [5:0]    change_q, change_d;
    logic [5:0]    credit_q, credit_d;
    logic          dispense_q, dispense_d;
    logic [1:0]    pid_q, pid_d;
    logic          reject_q, reject_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [5:0]    price_sel;
    logic [5:0]    coin_val;
    logic          coin_ok;
    logic [6:0]    sum7;
    logic          fits;

    // Price lookup and coin decode; overflow is checked one bit wider.
    always_comb begin
        price_sel = 6'(PRICE0);
        case (product_sel)
            2'd0:    price_sel = 6'(PRICE0);
            2'd1:    price_sel = 6'(PRICE1);
            2'd2:    price_sel = 6'(PRICE2);
            default: price_sel = 6'(PRICE3);
        endcase
        coin_val = 6'd0;
        coin_ok  = 1'b1;
        case (coin_code)
            2'b00:   coin_val = 6'd5;
            2'b01:   coin_val = 6'd10;
            2'b10:   coin_val = 6'd20;
            default: coin_ok  = 1'b0;
        endcase
        sum7 = {1'b0, credit_q} + {1'b0, coin_val};
        fits = (sum7 <= 7'd63);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cost_d     = cost_q;
        change_d   = change_q;
        credit_d   = credit_q;
        pid_d      = pid_q;
        hold_d     = hold_q;
        dispense_d = 1'b0;
        reject_d   = 1'b0;
        case (state_q)
            IDLE: begin
                reject_d = coin_valid;
                if (select_valid) begin
                    cost_d  = price_sel;
                    pid_d   = product_sel;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    reject_d = coin_valid;
                    change_d = credit_q;
                    credit_d = '0;
                    hold_d   = '0;
                    state_d  = HOLD;
                end else if (credit_q >= cost_q) begin
                    // Price already met: a coin arriving now would not be
                    // counted toward change, so it is returned.
                    reject_d   = coin_valid;
                    change_d   = credit_q - cost_q;
                    dispense_d = 1'b1;
                    state_d    = DISPENSE;
                end else if (coin_valid) begin
                    if (coin_ok && fits) begin
                        credit_d = sum7[5:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                reject_d = coin_valid;
                credit_d = '0;
                hold_d   = '0;
                state_d  = HOLD;
            end
            HOLD: begin
                reject_d = coin_valid;
                if (hold_q == HOLD_LAST) begin
                    change_d = '0;
                    cost_d   = '0;
                    pid_d    = '0;
                    state_d  = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cost_q     <= '0;
            change_q   <= '0;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            pid_q      <= '0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            cost_q     <= cost_d;
            change_q   <= change_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            pid_q      <= pid_d;
            reject_q   <= reject_d;
            busy_q     <= busy_d;
            hold_q     <= hold_d;
        end
    end

    assign cost_of_product = cost_q;
    assign change          = change_q;
    assign credit          = credit_q;
    assign dispense        = dispense_q;
    assign product_id      = pid_q;
    assign coin_reject     = reject_q;
    assign busy            = busy_q;

endmodule
